eda_lmax_scan: RTL and testbench
================================

// Module: eda_lmax_scan
// PURPOSE
//  Downstream consumer of the image RAM 3x3 window port. After the image is loaded, it walks center_addr over all M*N pixels in raster order.
//  For each pixel it compares the center against its valid neighbours and emits one classification record per pixel on a valid/ready stream.
//  It also counts local maxima. The output feeds the regional-max plateau resolver.
// PARAMETERS
//  M            `CFG_M            image rows
//  N            `CFG_N            image columns
//  PIXEL_WIDTH  `CFG_PIXEL_WIDTH  bits per pixel (8)
//  WINDOW_WIDTH `CFG_WINDOW_WIDTH window pixels (9)
//  ADDR_WIDTH   `CFG_ADDR_WIDTH   {i,j} address width = I_WIDTH+J_WIDTH
//  I_WIDTH      `CFG_I_WIDTH      row index width
//  J_WIDTH      `CFG_J_WIDTH      column index width
// PORTS
//  clk             in   1                          clock
//  reset_n         in   1                          reset, asynchronous, active-low
//  start           in   1                          1-cycle pulse, begin scan
//  busy            out  1                          scan in progress
//  done            out  1                          1-cycle pulse, last record accepted
//  center_addr     out  ADDR_WIDTH                 {i,j} to image RAM
//  window_values   in   PIXEL_WIDTH*WINDOW_WIDTH   slice 8=upleft .. 4=center .. 0=downright; invalid neighbours read 0
//  neigh_addr_valid in  WINDOW_WIDTH-1             bit7=upleft .. bit0=downright
//  out_valid       out  1                          record valid
//  out_ready       in   1                          downstream accepts
//  out_addr        out  ADDR_WIDTH                 pixel address of record
//  out_is_max      out  1                          center > every valid neighbour
//  out_plateau     out  1                          only with EDA_LMAX_PLATEAU_EN
//  max_count       out  ADDR_WIDTH+1               number of out_is_max records accepted this scan
// BEHAVIOUR
//  Reset: FSM=IDLE; center_addr=0; busy, done, out_valid, out_is_max, out_plateau=0; out_addr=0; max_count=0.
//  FSM states:
//   IDLE: start -> SCAN; clear center_addr and max_count.
//   SCAN: issue addresses; leave when the last address (M-1,N-1) is loaded into the output register -> DRAIN.
//   DRAIN: last record accepted -> DONE.
//   DONE: done=1 for exactly one cycle -> IDLE.
//  busy=1 in SCAN and DRAIN. start is ignored outside IDLE.
//  RAM read is combinational. The compare result is registered into a one-entry output register.
//  Latency: center_addr presented -> out_valid next cycle.
//  Load enable: (state==SCAN) && (!out_valid || out_ready). Full throughput is 1 pixel/cycle.
//  center_addr advances only on load. Raster stepping:
//   if j==N-1 then j=0, i=i+1; else j=j+1.
//   center_addr holds at (M-1,N-1) after the last load, with no wrap to 0.
//  Handshake: out_valid stays high and out_* stay stable until out_ready. No bubble is inserted while out_ready stays high.
//  Compare rule: neighbour k counts only if its valid bit is set (unsigned compare).
//   is_max = AND over k of (!valid[k] || center > nb[k]).
//   A 1x1 image (no valid neighbours) gives is_max=1.
//  max_count increments on out_valid && out_ready && out_is_max. It saturates at M*N and holds its value until the next start.
//  Simultaneous events:
//   - done and a new start in the same cycle: start is ignored.
//   - reset mid-scan: immediate return to reset values; any pending record is dropped.
// CONFIGURATION
//  EDA_LMAX_PLATEAU_EN defined:
//   out_plateau = !is_max && AND over k of (!valid[k] || center >= nb[k]) && OR over k of (valid[k] && center == nb[k]).
//  Not defined: the out_plateau port is present and tied to 0, with no compare logic.
// STRUCTURE
//  eda_global_define.svh / eda_pkg: lmax_state_e {IDLE,SCAN,DRAIN,DONE}, window slice index localparams (UL..DR, CENTER=4), record struct {addr,is_max,plateau}.
//  One sub-module: eda_window_cmp, a combinational compare of the center vs 8 neighbours that outputs is_max and plateau.
//  The FSM, address counter, output register and max_count live in the top.
// TESTING
//  1) M=N=4 ramp image p(i,j)=4i+j, out_ready=1 -> 16 records, only (3,3) is_max=1, max_count=1, done 17 cycles after start.
//  2) All-zero image -> no is_max records. With EDA_LMAX_PLATEAU_EN, all 16 records have plateau=1; otherwise plateau=0.
//  3) Single spike 200 at (1,2), others 10 -> only (1,2) is_max=1. Corner (0,0) is is_max=0. Corners only compare their 3 neighbours.
//  4) out_ready toggled 1,0,0,1 randomly -> records are in raster order with no loss or duplication, and out_* are stable while stalled.
//  5) Reset asserted mid-scan at pixel 7 -> all outputs reach reset values and no done pulse. A new start rescans from (0,0).
//  6) start pulsed during SCAN and during the DONE cycle -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/eda_lmax_scan_pkg.sv
// Shared types for the local-maximum scanner: FSM states and 3x3 window slice indices.
package eda_lmax_scan_pkg;

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} lmax_state_e;

  localparam int unsigned SliceUl     = 8;
  localparam int unsigned SliceU      = 7;
  localparam int unsigned SliceUr     = 6;
  localparam int unsigned SliceL      = 5;
  localparam int unsigned SliceCenter = 4;
  localparam int unsigned SliceR      = 3;
  localparam int unsigned SliceDl     = 2;
  localparam int unsigned SliceD      = 1;
  localparam int unsigned SliceDr     = 0;

  localparam int unsigned NumNeigh = 8;

  // Window slice for neighbour-valid bit k (bit 7 = upleft .. bit 0 = downright).
  localparam int unsigned NbSlice [NumNeigh] = '{SliceDr, SliceD, SliceDl, SliceR,
                                                 SliceL, SliceUr, SliceU, SliceUl};

endpackage

// File: rtl/eda_lmax_scan_window_cmp.sv
// Combinational compare of the window center against its valid neighbours.
// Plateau detection is built only when EDA_LMAX_PLATEAU_EN is defined.
module eda_lmax_scan_window_cmp
  import eda_lmax_scan_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned WINDOW_WIDTH = 9
) (
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
  input  logic [WINDOW_WIDTH-2:0]             neigh_addr_valid,
  output logic                                is_max,
  output logic                                plateau
);

  logic [PIXEL_WIDTH-1:0] center;
  logic [PIXEL_WIDTH-1:0] nb [NumNeigh];

  assign center = window_values[SliceCenter*PIXEL_WIDTH +: PIXEL_WIDTH];

  for (genvar k = 0; k < NumNeigh; k++) begin : g_nb
    assign nb[k] = window_values[NbSlice[k]*PIXEL_WIDTH +: PIXEL_WIDTH];
  end

  always_comb begin
    is_max = 1'b1;
    for (int k = 0; k < NumNeigh; k++) begin
      if (neigh_addr_valid[k] && (center <= nb[k])) is_max = 1'b0;
    end
  end

`ifdef EDA_LMAX_PLATEAU_EN
  logic ge_all;
  logic eq_any;

  always_comb begin
    ge_all = 1'b1;
    eq_any = 1'b0;
    for (int k = 0; k < NumNeigh; k++) begin
      if (neigh_addr_valid[k]) begin
        if (center < nb[k])  ge_all = 1'b0;
        if (center == nb[k]) eq_any = 1'b1;
      end
    end
  end

  assign plateau = !is_max && ge_all && eq_any;
`else
  assign plateau = 1'b0;
`endif

endmodule

// File: rtl/eda_lmax_scan.sv
// Raster scan of the image RAM window port, emitting one local-max record per pixel.
// Optional plateau flag is enabled with EDA_LMAX_PLATEAU_EN.
module eda_lmax_scan
  import eda_lmax_scan_pkg::*;
#(
  parameter int unsigned M            = 4,
  parameter int unsigned N            = 4,
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned WINDOW_WIDTH = 9,
  parameter int unsigned I_WIDTH      = 2,
  parameter int unsigned J_WIDTH      = 2,
  parameter int unsigned ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [ADDR_WIDTH-1:0]               center_addr,
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
  input  logic [WINDOW_WIDTH-2:0]             neigh_addr_valid,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ADDR_WIDTH-1:0]               out_addr,
  output logic                                out_is_max,
  output logic                                out_plateau,
  output logic [ADDR_WIDTH:0]                 max_count
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  is_max;
    logic                  plateau;
  } lmax_rec_t;

  localparam logic [I_WIDTH-1:0]  LastI       = I_WIDTH'(M - 1);
  localparam logic [J_WIDTH-1:0]  LastJ       = J_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH:0] MaxCountSat = (ADDR_WIDTH + 1)'(M * N);

  lmax_state_e           state_q;
  lmax_rec_t             rec_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [ADDR_WIDTH:0]   count_q;

  logic cmp_is_max;
  logic cmp_plateau;
  logic accept;
  logic load;
  logic at_last;

  eda_lmax_scan_window_cmp #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .WINDOW_WIDTH (WINDOW_WIDTH)
  ) u_cmp (
    .window_values    (window_values),
    .neigh_addr_valid (neigh_addr_valid),
    .is_max           (cmp_is_max),
    .plateau          (cmp_plateau)
  );

  assign accept  = valid_q && out_ready;
  assign load    = (state_q == StScan) && (!valid_q || out_ready);
  assign at_last = (addr_q == {LastI, LastJ});

  always_comb begin
    addr_next = addr_q;
    if (addr_q[J_WIDTH-1:0] == LastJ) begin
      addr_next[J_WIDTH-1:0]          = '0;
      addr_next[ADDR_WIDTH-1:J_WIDTH] = addr_q[ADDR_WIDTH-1:J_WIDTH] + I_WIDTH'(1);
    end else begin
      addr_next[J_WIDTH-1:0] = addr_q[J_WIDTH-1:0] + J_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      rec_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        valid_q <= 1'b0;
        if (rec_q.is_max && (count_q != MaxCountSat)) count_q <= count_q + (ADDR_WIDTH + 1)'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StScan;
            busy_q  <= 1'b1;
            addr_q  <= '0;
            count_q <= '0;
          end
        end
        StScan: begin
          if (load) begin
            valid_q <= 1'b1;
            rec_q   <= '{addr: addr_q, is_max: cmp_is_max, plateau: cmp_plateau};
            // The last address stays on center_addr; the scan never wraps.
            if (at_last) state_q <= StDrain;
            else         addr_q  <= addr_next;
          end
        end
        StDrain: begin
          if (accept) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign center_addr = addr_q;
  assign out_valid   = valid_q;
  assign out_addr    = rec_q.addr;
  assign out_is_max  = rec_q.is_max;
  assign out_plateau = rec_q.plateau;
  assign max_count   = count_q;

endmodule

// File: tb/tb_eda_lmax_scan.sv
// Randomised self-checking bench for eda_lmax_scan against a per-pixel neighbourhood model.
module tb_eda_lmax_scan;

  localparam int M  = 4;
  localparam int N  = 4;
  localparam int PW = 8;
  localparam int WW = 9;
  localparam int IW = 2;
  localparam int JW = 2;
  localparam int AW = IW + JW;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic            busy;
  logic            done;
  logic [AW-1:0]   center_addr;
  logic [PW*WW-1:0] window_values;
  logic [WW-2:0]   neigh_addr_valid;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_addr;
  logic            out_is_max;
  logic            out_plateau;
  logic [AW:0]     max_count;

  typedef struct {
    int unsigned addr;
    bit          is_max;
    bit          plateau;
  } rec_t;

  int unsigned img [M][N];
  rec_t        exp_q [$];
  int          exp_max;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  eda_lmax_scan #(
    .M            (M),
    .N            (N),
    .PIXEL_WIDTH  (PW),
    .WINDOW_WIDTH (WW),
    .I_WIDTH      (IW),
    .J_WIDTH      (JW),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .center_addr      (center_addr),
    .window_values    (window_values),
    .neigh_addr_valid (neigh_addr_valid),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_addr         (out_addr),
    .out_is_max       (out_is_max),
    .out_plateau      (out_plateau),
    .max_count        (max_count)
  );

  // Image RAM window port: combinational read, out-of-image pixels read 0.
  always_comb begin
    int ci, cj, s, b;
    window_values    = '0;
    neigh_addr_valid = '0;
    ci = int'(center_addr[AW-1:JW]);
    cj = int'(center_addr[JW-1:0]);
    s  = 8;
    b  = 7;
    for (int di = -1; di <= 1; di++) begin
      for (int dj = -1; dj <= 1; dj++) begin
        if (ci + di >= 0 && ci + di < M && cj + dj >= 0 && cj + dj < N) begin
          window_values[s*PW +: PW] = PW'(img[ci+di][cj+dj]);
          if (!(di == 0 && dj == 0)) neigh_addr_valid[b] = 1'b1;
        end
        if (!(di == 0 && dj == 0)) b--;
        s--;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_img(input int mode);
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        case (mode)
          0:       img[i][j] = 4 * i + j;
          1:       img[i][j] = 0;
          2:       img[i][j] = (i == 1 && j == 2) ? 200 : 10;
          default: img[i][j] = $urandom_range(0, 3);
        endcase
      end
    end
  endtask

  task automatic build_expected();
    rec_t r;
    exp_q.delete();
    exp_max = 0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        bit mx, ge, eq;
        mx = 1; ge = 1; eq = 0;
        for (int di = -1; di <= 1; di++) begin
          for (int dj = -1; dj <= 1; dj++) begin
            if ((di != 0 || dj != 0) && i + di >= 0 && i + di < M && j + dj >= 0 && j + dj < N)
            begin
              if (!(img[i][j] > img[i+di][j+dj])) mx = 0;
              if (img[i][j] < img[i+di][j+dj])    ge = 0;
              if (img[i][j] == img[i+di][j+dj])   eq = 1;
            end
          end
        end
        r.addr   = i * N + j;
        r.is_max = mx;
`ifdef EDA_LMAX_PLATEAU_EN
        r.plateau = !mx && ge && eq;
`else
        r.plateau = 0;
`endif
        exp_q.push_back(r);
        if (mx) exp_max++;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_is_max"}, out_is_max, 0);
    check_eq({tag, "_out_plateau"}, out_plateau, 0);
    check_eq({tag, "_out_addr"}, out_addr, 0);
    check_eq({tag, "_center_addr"}, center_addr, 0);
    check_eq({tag, "_max_count"}, max_count, 0);
  endtask

  // Called on a negedge. reset_at > 0 aborts the scan with a reset at that cycle.
  task automatic run_scan(input bit rand_ready, input int spur_at, input int reset_at);
    int          cyc, dones, done_cyc, got;
    bit          stalled;
    logic [AW-1:0] st_addr;
    logic        st_max, st_plat;
    rec_t        r;
    cyc = 0; dones = 0; done_cyc = -1; got = 0; stalled = 0;
    st_addr = '0; st_max = 0; st_plat = 0;
    build_expected();
    start = 1'b1;
    out_ready = 1'b1;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc == spur_at);
      if (cyc == 1) begin
        check_eq("busy_after_start", busy, 1);
        check_eq("first_center_addr", center_addr, 0);
        check_eq("no_early_valid", out_valid, 0);
      end
      if (reset_at > 0 && cyc == reset_at) begin
        reset_n = 1'b0;
        #1;
        check_reset_values("midscan_reset");
        @(negedge clk);
        check_eq("no_done_in_reset", done, 0);
        check_eq("reset_dones", dones, 0);
        reset_n = 1'b1;
        start   = 1'b0;
        return;
      end
      if (stalled) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_addr", out_addr, st_addr);
        check_eq("stall_is_max", out_is_max, st_max);
        check_eq("stall_plateau", out_plateau, st_plat);
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        start = 1'b1;  // lands in the DONE cycle and must be ignored
      end
      if (dones > 0 && cyc == done_cyc + 4) break;
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      stalled = 0;
      if (out_valid) begin
        if (out_ready) begin
          got++;
          if (exp_q.size() == 0) begin
            check_eq("extra_record", 1, 0);
          end else begin
            r = exp_q.pop_front();
            check_eq("rec_addr", out_addr, r.addr);
            check_eq("rec_is_max", out_is_max, r.is_max);
            check_eq("rec_plateau", out_plateau, r.plateau);
          end
        end else begin
          stalled = 1;
          st_addr = out_addr;
          st_max  = out_is_max;
          st_plat = out_plateau;
        end
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    check_eq("done_pulses", dones, 1);
    check_eq("records_seen", got, M * N);
    check_eq("records_left", exp_q.size(), 0);
    check_eq("max_count", max_count, exp_max);
    check_eq("idle_after_done", busy, 0);
    check_eq("center_holds_last", center_addr, M * N - 1);
    if (!rand_ready) check_eq("done_latency", done_cyc - 1, M * N + 1);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    fill_img(1);
    repeat (2) @(negedge clk);
    check_reset_values("por");
    reset_n = 1'b1;
    @(negedge clk);

    fill_img(0); run_scan(0, 0, 0);        // ramp: only (3,3) is a maximum
    fill_img(1); run_scan(0, 0, 0);        // flat image
    fill_img(2); run_scan(0, 0, 0);        // single spike
    fill_img(3); run_scan(1, 0, 0);        // random image, random back-pressure
    fill_img(0); run_scan(1, 0, 9);        // reset around pixel 7
    @(negedge clk);
    run_scan(0, 0, 0);                     // rescan from (0,0)
    fill_img(2); run_scan(1, 5, 0);        // stray start during SCAN
    for (int t = 0; t < 4; t++) begin
      fill_img(3);
      run_scan(1, $urandom_range(2, 12), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
